axi4_slv_mem: RTL and testbench

AXI4 full-protocol slave memory that sits directly downstream of the axi_vip_wrapper burst master and consumes its write and read bursts. It provides a MEM_DEPTH-word register-array memory mapped at BASE_ADDR. Write and read channels run independent single-outstanding state machines. Out-of-window or unsupported bursts are reported with SLVERR.

---
 rtl/axi4_slv_pkg.sv | 56 +++++
 rtl/axi4_slv_mem_array.sv | 30 +++
 rtl/axi4_slv_mem.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_slv_mem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slv_pkg.sv
// Shared types and helpers for the AXI4 slave memory: response and burst
// encodings, channel state enums, burst legality and beat address stepping.
package axi4_slv_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Address of the following beat. FIXED holds; every other encoding
    // (including the unsupported WRAP and reserved ones) steps like INCR.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [63:0] nxt_v;
        if (burst == BURST_FIXED) begin
            nxt_v = addr;
        end else begin
            nxt_v = addr + (64'd1 << size);
        end
        return nxt_v;
    endfunction

    // High when a burst uses an unsupported type or a beat wider than the bus.
    function automatic logic burst_check(input logic [1:0] burst,
                                         input logic [2:0] size,
                                         input logic [2:0] max_size);
        logic bad_v;
        if ((burst == BURST_FIXED) || (burst == BURST_INCR)) begin
            bad_v = (size > max_size);
        end else begin
            bad_v = 1'b1;
        end
        return bad_v;
    endfunction

endpackage

// File: rtl/axi4_slv_mem_array.sv
// Word-organised storage with per-byte write enables, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module axi4_slv_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_idx,
    input  logic [DATA_WIDTH/8-1:0]      wr_strb,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clock) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Asynchronous read: a same-edge write is seen only after that edge.
    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/axi4_slv_mem.sv
// AXI4 slave memory mapped at BASE_ADDR. Write and read channels each run an
// independent single-outstanding FSM; illegal or out-of-window bursts answer
// SLVERR. All channel outputs are driven straight from flops.
module axi4_slv_mem
    import axi4_slv_pkg::*;
#(
    parameter int                    ID_WIDTH   = 1,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);
    localparam logic [2:0]          MAX_SIZE = 3'(BYTE_SHIFT);

    // One extra bit so the window top cannot wrap at the end of the space.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] ax_v;
        ax_v = {1'b0, a};
        return (ax_v >= WIN_LO) && (ax_v < WIN_HI);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> BYTE_SHIFT);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        return ADDR_WIDTH'(next_addr(64'(a), size, burst));
    endfunction

    // ---------------- write channel ----------------
    wr_state_t             wr_state_r, wr_state_s;
    logic                  awready_r, awready_s;
    logic                  wready_r, wready_s;
    logic                  bvalid_r, bvalid_s;
    logic [1:0]            bresp_r, bresp_s;
    logic [ID_WIDTH-1:0]   bid_r, bid_s;
    logic [ID_WIDTH-1:0]   wr_id_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [7:0]            wr_len_r;
    logic [2:0]            wr_size_r;
    logic [1:0]            wr_burst_r;
    logic                  wr_chk_err_r;
    logic                  wr_win_err_r;
    logic [8:0]            wr_cnt_r;
    logic                  aw_hs_s, w_hs_s, b_hs_s;
    logic                  wr_beat_oob_s, mem_we_s, wr_final_err_s;

    assign aw_hs_s        = S_AXI_AWVALID & awready_r;
    assign w_hs_s         = S_AXI_WVALID & wready_r;
    assign b_hs_s         = bvalid_r & S_AXI_BREADY;
    assign wr_beat_oob_s  = ~in_window(wr_addr_r);
    assign mem_we_s       = w_hs_s & ~wr_chk_err_r & ~wr_beat_oob_s;
    // wr_cnt_r is the index of the current beat, so on WLAST it must equal LEN.
    assign wr_final_err_s = wr_chk_err_r | wr_win_err_r | wr_beat_oob_s |
                            (wr_cnt_r != {1'b0, wr_len_r});

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_r <= W_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write FSM next-state decode.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE:  if (aw_hs_s) wr_state_s = W_DATA; else wr_state_s = W_IDLE;
            W_DATA:  if (w_hs_s && S_AXI_WLAST) wr_state_s = W_RESP; else wr_state_s = W_DATA;
            W_RESP:  if (b_hs_s) wr_state_s = W_IDLE; else wr_state_s = W_RESP;
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write channel output values for the coming cycle, derived from next state.
    always_comb begin
        awready_s = (wr_state_s == W_IDLE);
        wready_s  = (wr_state_s == W_DATA);
        bvalid_s  = (wr_state_s == W_RESP);
        if (wr_state_s == W_RESP) begin
            bid_s = wr_id_r;
            if (wr_state_r == W_DATA) begin
                bresp_s = wr_final_err_s ? RESP_SLVERR : RESP_OKAY;
            end else begin
                bresp_s = bresp_r;
            end
        end else begin
            bid_s   = {ID_WIDTH{1'b0}};
            bresp_s = RESP_OKAY;
        end
    end

    // Write channel output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            bid_r     <= {ID_WIDTH{1'b0}};
        end else begin
            awready_r <= awready_s;
            wready_r  <= wready_s;
            bvalid_r  <= bvalid_s;
            bresp_r   <= bresp_s;
            bid_r     <= bid_s;
        end
    end

    // Write burst context: latched on AW, stepped and error-tracked per beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_id_r      <= {ID_WIDTH{1'b0}};
            wr_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_len_r     <= 8'd0;
            wr_size_r    <= 3'd0;
            wr_burst_r   <= 2'b00;
            wr_chk_err_r <= 1'b0;
            wr_win_err_r <= 1'b0;
            wr_cnt_r     <= 9'd0;
        end else if (aw_hs_s) begin
            wr_id_r      <= S_AXI_AWID;
            wr_addr_r    <= S_AXI_AWADDR;
            wr_len_r     <= S_AXI_AWLEN;
            wr_size_r    <= S_AXI_AWSIZE;
            wr_burst_r   <= S_AXI_AWBURST;
            wr_chk_err_r <= burst_check(S_AXI_AWBURST, S_AXI_AWSIZE, MAX_SIZE);
            wr_win_err_r <= 1'b0;
            wr_cnt_r     <= 9'd0;
        end else if (w_hs_s) begin
            wr_addr_r    <= step_addr(wr_addr_r, wr_size_r, wr_burst_r);
            wr_cnt_r     <= (wr_cnt_r == 9'h1FF) ? wr_cnt_r : wr_cnt_r + 9'd1;
            wr_win_err_r <= wr_win_err_r | wr_beat_oob_s;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t             rd_state_r, rd_state_s;
    logic                  arready_r, arready_s;
    logic                  rvalid_r, rvalid_s;
    logic                  rlast_r, rlast_s;
    logic [1:0]            rresp_r, rresp_s;
    logic [ID_WIDTH-1:0]   rid_r, rid_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [7:0]            rd_len_r;
    logic [2:0]            rd_size_r;
    logic [1:0]            rd_burst_r;
    logic                  rd_chk_err_r;
    logic [7:0]            rd_cnt_r;
    logic                  ar_hs_s, r_hs_s, rd_load_s;
    logic [ADDR_WIDTH-1:0] rd_beat_addr_s;
    logic                  rd_beat_err_s, rd_beat_last_s;
    logic [DATA_WIDTH-1:0] mem_rd_data_s;

    assign ar_hs_s   = S_AXI_ARVALID & arready_r;
    assign r_hs_s    = rvalid_r & S_AXI_RREADY;
    // A beat is fetched on the AR handshake and on every non-final R handshake.
    assign rd_load_s = ar_hs_s | (r_hs_s & ~rlast_r);

    // Address, error and last flag of the beat being fetched this cycle.
    always_comb begin
        if (rd_state_r == R_IDLE) begin
            rd_beat_addr_s = S_AXI_ARADDR;
            rd_beat_err_s  = burst_check(S_AXI_ARBURST, S_AXI_ARSIZE, MAX_SIZE) |
                             ~in_window(S_AXI_ARADDR);
            rd_beat_last_s = (S_AXI_ARLEN == 8'd0);
        end else begin
            rd_beat_addr_s = step_addr(rd_addr_r, rd_size_r, rd_burst_r);
            rd_beat_err_s  = rd_chk_err_r | ~in_window(rd_beat_addr_s);
            rd_beat_last_s = ((rd_cnt_r + 8'd1) == rd_len_r);
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE:  if (ar_hs_s) rd_state_s = R_DATA; else rd_state_s = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_r) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read channel output values: load a new beat, clear when idle, else hold.
    always_comb begin
        arready_s = (rd_state_s == R_IDLE);
        rvalid_s  = (rd_state_s == R_DATA);
        if (rd_load_s) begin
            rdata_s = rd_beat_err_s ? {DATA_WIDTH{1'b0}} : mem_rd_data_s;
            rresp_s = rd_beat_err_s ? RESP_SLVERR : RESP_OKAY;
            rlast_s = rd_beat_last_s;
            rid_s   = (rd_state_r == R_IDLE) ? S_AXI_ARID : rid_r;
        end else if (rd_state_s == R_IDLE) begin
            rdata_s = {DATA_WIDTH{1'b0}};
            rresp_s = RESP_OKAY;
            rlast_s = 1'b0;
            rid_s   = {ID_WIDTH{1'b0}};
        end else begin
            rdata_s = rdata_r;
            rresp_s = rresp_r;
            rlast_s = rlast_r;
            rid_s   = rid_r;
        end
    end

    // Read channel output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= 2'b00;
            rid_r     <= {ID_WIDTH{1'b0}};
            rdata_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            rlast_r   <= rlast_s;
            rresp_r   <= rresp_s;
            rid_r     <= rid_s;
            rdata_r   <= rdata_s;
        end
    end

    // Read burst context: latched on AR, advanced whenever a beat is fetched.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_addr_r    <= {ADDR_WIDTH{1'b0}};
            rd_len_r     <= 8'd0;
            rd_size_r    <= 3'd0;
            rd_burst_r   <= 2'b00;
            rd_chk_err_r <= 1'b0;
            rd_cnt_r     <= 8'd0;
        end else if (ar_hs_s) begin
            rd_addr_r    <= S_AXI_ARADDR;
            rd_len_r     <= S_AXI_ARLEN;
            rd_size_r    <= S_AXI_ARSIZE;
            rd_burst_r   <= S_AXI_ARBURST;
            rd_chk_err_r <= burst_check(S_AXI_ARBURST, S_AXI_ARSIZE, MAX_SIZE);
            rd_cnt_r     <= 8'd0;
        end else if (rd_load_s) begin
            rd_addr_r    <= rd_beat_addr_s;
            rd_cnt_r     <= rd_cnt_r + 8'd1;
        end
    end

    axi4_slv_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clock   (ACLK),
        .wr_en   (mem_we_s),
        .wr_idx  (word_idx(wr_addr_r)),
        .wr_strb (S_AXI_WSTRB),
        .wr_data (S_AXI_WDATA),
        .rd_idx  (word_idx(rd_beat_addr_s)),
        .rd_data (mem_rd_data_s)
    );

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_BID     = bid_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;

endmodule

// File: tb/tb_axi4_slv_mem.sv
// Directed bench for axi4_slv_mem: bursts, strobes, FIXED, error responses,
// read backpressure and reset in the middle of a read burst.
module tb_axi4_slv_mem;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_d [16];
    logic [3:0]  wr_s [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [0:0]  rd_id [16];
    logic        bvalid_at_last;
    logic        rvalid_after_ar;
    logic [1:0]  resp;
    logic [0:0]  bid;
    int          got;

    always #5 ACLK = ~ACLK;

    axi4_slv_mem dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            output logic [1:0] b_resp, output logic [0:0] b_id);
        int n;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        n = 0;
        while (S_AXI_AWREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
        chk("aw_wait", 64'(n < 50), 64'd1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA = wr_d[i]; S_AXI_WSTRB = wr_s[i];
            S_AXI_WLAST = (i == nbeats - 1); S_AXI_WVALID = 1'b1;
            n = 0;
            while (S_AXI_WREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
            chk("w_wait", 64'(n < 50), 64'd1);
            @(posedge ACLK); #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        bvalid_at_last = S_AXI_BVALID;
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
        chk("b_wait", 64'(n < 50), 64'd1);
        b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           output int beats);
        int n;
        int cyc;
        bit done;
        bit prev_stall;
        logic [31:0] prev_d;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (S_AXI_ARREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
        chk("ar_wait", 64'(n < 50), 64'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        rvalid_after_ar = S_AXI_RVALID;
        beats = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_d = 32'd0;
        while (!done && beats < 16 && cyc < 100) begin
            S_AXI_RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (prev_stall) chk("r_hold", 64'(S_AXI_RDATA), 64'(prev_d));
            prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
            prev_d = S_AXI_RDATA;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                rd_d[beats] = S_AXI_RDATA; rd_resp[beats] = S_AXI_RRESP;
                rd_last[beats] = S_AXI_RLAST; rd_id[beats] = S_AXI_RID;
                done = S_AXI_RLAST;
                beats++;
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'd0; S_AXI_AWLEN = 8'd0; S_AXI_AWSIZE = 3'd0;
        S_AXI_AWBURST = 2'b00; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0;
        S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'd0; S_AXI_ARLEN = 8'd0; S_AXI_ARSIZE = 3'd0;
        S_AXI_ARBURST = 2'b00; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin wr_d[i] = 32'd0; wr_s[i] = 4'hF; end

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
        chk("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        chk("rst_wready",  64'(S_AXI_WREADY),  64'd0);
        chk("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
        chk("rst_rvalid_rlast", 64'({S_AXI_RVALID, S_AXI_RLAST}), 64'd0);
        chk("rst_resps", 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
        chk("rst_ids_rdata", 64'({S_AXI_BID, S_AXI_RID, S_AXI_RDATA}), 64'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        chk("rel_awready", 64'(S_AXI_AWREADY), 64'd1);
        chk("rel_arready", 64'(S_AXI_ARREADY), 64'd1);

        // INCR write 0x11..0x44 then read back
        for (int i = 0; i < 4; i++) begin wr_d[i] = 32'(32'h11 * (i + 1)); wr_s[i] = 4'hF; end
        do_write(1'b1, 32'h8000_0000, 8'd3, 3'd2, 2'b01, 4, resp, bid);
        chk("incr_bresp", 64'(resp), 64'd0);
        chk("incr_bid", 64'(bid), 64'd1);
        do_read(1'b1, 32'h8000_0000, 8'd3, 3'd2, 2'b01, 1'b0, got);
        chk("incr_rvalid_latency", 64'(rvalid_after_ar), 64'd1);
        chk("incr_beats", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", 64'(rd_d[i]), 64'(32'h11 * (i + 1)));
            chk("incr_rlast", 64'(rd_last[i]), 64'(i == 3));
            chk("incr_rresp", 64'(rd_resp[i]), 64'd0);
            chk("incr_rid", 64'(rd_id[i]), 64'd1);
        end
        chk("incr_rvalid_after", 64'(S_AXI_RVALID), 64'd0);

        // Read with RREADY toggling 1-0-1-0
        do_read(1'b0, 32'h8000_0000, 8'd3, 3'd2, 2'b01, 1'b1, got);
        chk("bp_beats", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdata", 64'(rd_d[i]), 64'(32'h11 * (i + 1)));
            chk("bp_rlast", 64'(rd_last[i]), 64'(i == 3));
        end

        // Strobes over 0xFFFFFFFF, then FIXED read of two beats
        wr_d[0] = 32'hFFFF_FFFF; wr_s[0] = 4'hF;
        do_write(1'b0, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1, resp, bid);
        chk("strb_fill_bresp", 64'(resp), 64'd0);
        wr_d[0] = 32'hAABB_CCDD; wr_s[0] = 4'b0101;
        do_write(1'b0, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1, resp, bid);
        chk("strb_bresp", 64'(resp), 64'd0);
        do_read(1'b0, 32'h8000_0010, 8'd1, 3'd2, 2'b00, 1'b0, got);
        chk("fixed_beats", 64'(got), 64'd2);
        chk("fixed_rdata0", 64'(rd_d[0]), 64'h0000_0000_FFBB_FFDD);
        chk("fixed_rdata1", 64'(rd_d[1]), 64'h0000_0000_FFBB_FFDD);
        chk("fixed_rlast", 64'({rd_last[0], rd_last[1]}), 64'd1);

        // Out-of-window write must not alias onto the top word
        wr_d[0] = 32'hCAFE_F00D; wr_s[0] = 4'hF;
        do_write(1'b0, 32'h8000_03FC, 8'd0, 3'd2, 2'b01, 1, resp, bid);
        chk("top_word_bresp", 64'(resp), 64'd0);
        wr_d[0] = 32'h1234_5678;
        do_write(1'b1, 32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 1, resp, bid);
        chk("oow_bresp", 64'(resp), 64'd2);
        chk("oow_bid", 64'(bid), 64'd1);
        // Read the last word and step past the window end
        do_read(1'b0, 32'h8000_03FC, 8'd1, 3'd2, 2'b01, 1'b0, got);
        chk("edge_beats", 64'(got), 64'd2);
        chk("edge_rdata0", 64'(rd_d[0]), 64'h0000_0000_CAFE_F00D);
        chk("edge_rresp0", 64'(rd_resp[0]), 64'd0);
        chk("edge_rresp1", 64'(rd_resp[1]), 64'd2);
        chk("edge_rdata1", 64'(rd_d[1]), 64'd0);

        // WRAP read: every beat SLVERR
        do_read(1'b1, 32'h8000_0000, 8'd3, 3'd2, 2'b10, 1'b0, got);
        chk("wrap_beats", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) chk("wrap_rresp", 64'(rd_resp[i]), 64'd2);

        // SIZE wider than the bus
        do_read(1'b0, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 1'b0, got);
        chk("size_beats", 64'(got), 64'd1);
        chk("size_rresp", 64'(rd_resp[0]), 64'd2);

        // WLAST on beat 2 of a 4-beat burst
        wr_d[0] = 32'h0000_0055; wr_d[1] = 32'h0000_0066; wr_s[0] = 4'hF; wr_s[1] = 4'hF;
        do_write(1'b0, 32'h8000_0020, 8'd3, 3'd2, 2'b01, 2, resp, bid);
        chk("early_bvalid", 64'(bvalid_at_last), 64'd1);
        chk("early_bresp", 64'(resp), 64'd2);

        // Reset during a stalled read burst
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h8000_0000; S_AXI_ARLEN = 8'd3;
        S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        got = 0;
        while (S_AXI_ARREADY !== 1'b1 && got < 50) begin @(posedge ACLK); #1; got++; end
        chk("mid_ar_wait", 64'(got < 50), 64'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("mid_rvalid_before", 64'(S_AXI_RVALID), 64'd1);
        ARESETN = 1'b0;
        #1;
        chk("mid_rvalid_reset", 64'(S_AXI_RVALID), 64'd0);
        chk("mid_rlast_reset", 64'(S_AXI_RLAST), 64'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        chk("mid_arready_after", 64'(S_AXI_ARREADY), 64'd1);
        do_read(1'b1, 32'h8000_0004, 8'd0, 3'd2, 2'b01, 1'b0, got);
        chk("post_beats", 64'(got), 64'd1);
        chk("post_rdata", 64'(rd_d[0]), 64'h0000_0000_0000_0022);
        chk("post_rresp_rlast", 64'({rd_resp[0], rd_last[0]}), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
